crossbar_output_arbiter: RTL and testbench
==========================================

// Module: crossbar_output_arbiter
// PURPOSE
//  Per-output round-robin arbiter/scheduler for the 4x4 crossbar switch.
//  Each input port requests one destination output port. For every output, the block grants
//  ownership to one input and holds it until the packet ends or a timeout expires.
//  Drives the 3-bit Answer select of each output-side 4:1 connection mux.
//  Answer is {valid, src[1:0]}. Sits between the ingress port controllers and the crossbar.
// PARAMETERS
//  NUM_PORTS    4    crossbar dimension; fixed at 4 (2-bit port ids), not to be overridden
//  TIMEOUT_W    8    width of per-output hold counter
//  TIMEOUT_MAX  200  max BUSY cycles per grant before forced release; 0 disables timeout
// PORTS
//  clk          in   1  clock, all logic on rising edge
//  reset        in   1  synchronous reset, active-high
//  req          in   4  req[i]: input i has a packet pending/in flight
//  req_dest     in   8  dest output of input i at [2i+1:2i]; valid while req[i]
//  req_last     in   4  req_last[i]: input i transfers its last beat this cycle
//  grant        out  4  grant[i]: input i currently owns an output (registered)
//  answer0      out  3  select for output 0: [2]=valid, [1:0]=source input
//  answer1      out  3  select for output 1, same format
//  answer2      out  3  select for output 2, same format
//  answer3      out  3  select for output 3, same format
//  timeout_evt  out  4  1-cycle pulse: output o grant force-released by timeout
// BEHAVIOUR
//  Per output o: state IDLE/BUSY, owner[1:0], rr_ptr[1:0], hold_cnt[TIMEOUT_W-1:0].
//  Reset (sync, reset=1 at edge): all FSMs IDLE, answerN=3'b000, grant=0, timeout_evt=0,
//   rr_ptr=0, hold_cnt=0. Reset mid-packet drops every grant at that edge; no completion.
//  IDLE, candidates for o: every i with req[i] & req_dest[i]==o & !grant[i].
//   Pick the first candidate from rr_ptr upward, wrapping 3->0.
//   Next edge: BUSY, owner=i, answer_o={1'b1,i}, grant[i]=1, rr_ptr=(i+1)%4, hold_cnt=0.
//   No candidate: remain IDLE, answer_o=3'b000.
//  Latency: req sampled at edge t, so answer/grant are visible after edge t+1 (1 cycle).
//  BUSY: req_dest[owner] changes are ignored; ownership is fixed until release.
//   Release condition: (req_last[owner] | !req[owner]). On that edge: IDLE,
//   answer_o=3'b000, grant[owner]=0.
//   Timeout: hold_cnt increments each BUSY cycle. If TIMEOUT_MAX!=0 and
//   hold_cnt==TIMEOUT_MAX-1 with no release: force release (same as above) and set
//   timeout_evt[o]=1 for exactly one cycle.
//   Release and timeout on the same cycle: treat as a normal release; timeout_evt stays 0.
//  Every grant is followed by at least one IDLE cycle on that output (1-cycle bubble).
//   A request arriving in the release cycle is arbitrated in the following IDLE cycle.
//  An input holds at most one grant. Because req_dest selects one output, no cross-output
//   conflict is possible; !grant[i] blocks a re-grant while the old grant is still held.
//  grant[i] = OR over o of (BUSY_o & owner_o==i), taken from registered state.
//  answer_o[1:0]=2'b00 whenever answer_o[2]=0.
//  req_last[i] is ignored while grant[i]=0.
//  rr_ptr advances only on grant, never on release or timeout.
// TESTING
//  1 reset=1 for 2 cycles with req=4'hF -> answer0..3=3'b000, grant=0, timeout_evt=0.
//  2 req=4'b0001, dest0=2 -> one cycle later answer2=3'b100, grant=4'b0001;
//    req_last[0] pulsed 5 cycles later -> answer2=000 and grant=0 on the next edge.
//  3 req=4'hF, all dest=1, each owner asserts last after 3 beats -> grants go 0,1,2,3,0,
//    each followed by one IDLE cycle.
//  4 all four inputs request distinct outputs (dest=3,2,1,0) in one cycle -> all four
//    answers valid on the same next cycle: answer3=100, answer2=101, answer1=110,
//    answer0=111; grant=4'hF.
//  5 TIMEOUT_MAX=4, input1 granted output0, never last -> release after 4 BUSY cycles;
//    timeout_evt[0] pulses 1 cycle; input1 is re-granted after the IDLE bubble.
//  6 reset asserted while answer1=3'b110 -> answer1=000, grant=0 at that edge;
//    rr_ptr back to 0, so simultaneous req from inputs 3 and 0 to output 1 grants input 0.

Source files
------------

// File: rtl/crossbar_output_arbiter.sv
// Per-output round-robin scheduler for a 4x4 crossbar: each output grants one input and holds
// that grant until the packet ends, the request drops, or the hold timer expires.
module crossbar_output_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [7:0] req_dest,
  input  logic [3:0] req_last,
  output logic [3:0] grant,
  output logic [2:0] answer0,
  output logic [2:0] answer1,
  output logic [2:0] answer2,
  output logic [2:0] answer3,
  output logic [3:0] timeout_evt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam bit                   TO_EN     = (TIMEOUT_MAX != 0);
  localparam logic [TIMEOUT_W-1:0] HOLD_LAST = TIMEOUT_W'(TO_EN ? TIMEOUT_MAX - 1 : 0);

  state_t               r_state    [NUM_PORTS];
  state_t               w_state_nxt[NUM_PORTS];
  logic [1:0]           r_owner    [NUM_PORTS];
  logic [1:0]           w_owner_nxt[NUM_PORTS];
  logic [1:0]           r_rr_ptr   [NUM_PORTS];
  logic [1:0]           w_rr_nxt   [NUM_PORTS];
  logic [TIMEOUT_W-1:0] r_hold_cnt [NUM_PORTS];
  logic [TIMEOUT_W-1:0] w_hold_nxt [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_timeout_evt;
  logic [NUM_PORTS-1:0] w_timeout_nxt;
  logic [NUM_PORTS-1:0] w_grant;
  logic [NUM_PORTS-1:0] w_cand     [NUM_PORTS];
  logic [2:0]           w_pick     [NUM_PORTS];
  logic [2:0]           w_answer   [NUM_PORTS];

  // Returns {found, index} of the first set candidate at or after ptr, wrapping 3->0.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    w_grant = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (r_state[o] == S_BUSY) w_grant[r_owner[o]] = 1'b1;
    end
  end

  // An input already holding a grant elsewhere is excluded so it never owns two outputs.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_cand[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_cand[o][i] = req[i] && (req_dest[2*i +: 2] == 2'(o)) && !w_grant[i];
      end
      w_pick[o] = rr_pick(w_cand[o], r_rr_ptr[o]);
    end
  end

  always_comb begin
    w_timeout_nxt = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_state_nxt[o] = r_state[o];
      w_owner_nxt[o] = r_owner[o];
      w_rr_nxt[o]    = r_rr_ptr[o];
      w_hold_nxt[o]  = r_hold_cnt[o];
      case (r_state[o])
        S_IDLE: begin
          if (w_pick[o][2]) begin
            w_state_nxt[o] = S_BUSY;
            w_owner_nxt[o] = w_pick[o][1:0];
            w_rr_nxt[o]    = w_pick[o][1:0] + 2'd1;
            w_hold_nxt[o]  = '0;
          end
        end
        S_BUSY: begin
          if (req_last[r_owner[o]] || !req[r_owner[o]]) begin
            w_state_nxt[o] = S_IDLE;
          end else if (TO_EN && (r_hold_cnt[o] == HOLD_LAST)) begin
            w_state_nxt[o]   = S_IDLE;
            w_timeout_nxt[o] = 1'b1;
          end else begin
            w_hold_nxt[o] = r_hold_cnt[o] + 1'b1;
          end
        end
        default: w_state_nxt[o] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_state[o]    <= S_IDLE;
        r_owner[o]    <= 2'd0;
        r_rr_ptr[o]   <= 2'd0;
        r_hold_cnt[o] <= '0;
      end
      r_timeout_evt <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_state[o]    <= w_state_nxt[o];
        r_owner[o]    <= w_owner_nxt[o];
        r_rr_ptr[o]   <= w_rr_nxt[o];
        r_hold_cnt[o] <= w_hold_nxt[o];
      end
      r_timeout_evt <= w_timeout_nxt;
    end
  end

  // Source bits are forced to zero whenever the select is not valid.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_answer[o] = (r_state[o] == S_BUSY) ? {1'b1, r_owner[o]} : 3'b000;
    end
  end

  assign grant       = w_grant;
  assign timeout_evt = r_timeout_evt;
  assign answer0     = w_answer[0];
  assign answer1     = w_answer[1];
  assign answer2     = w_answer[2];
  assign answer3     = w_answer[3];

endmodule

// File: tb/tb_crossbar_output_arbiter.sv
// Directed bench for crossbar_output_arbiter: a cycle table plus hand sequences for
// round-robin rotation and hold-timer release.
module tb_crossbar_output_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [7:0] req_dest;
  logic [3:0] req_last;

  logic [3:0] grant, grant_t;
  logic [2:0] a0, a1, a2, a3, a0_t, a1_t, a2_t, a3_t;
  logic [3:0] tevt, tevt_t;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  crossbar_output_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_dest(req_dest), .req_last(req_last),
    .grant(grant), .answer0(a0), .answer1(a1), .answer2(a2), .answer3(a3),
    .timeout_evt(tevt)
  );

  crossbar_output_arbiter #(.TIMEOUT_MAX(4)) dut_t (
    .clk(clk), .reset(reset), .req(req), .req_dest(req_dest), .req_last(req_last),
    .grant(grant_t), .answer0(a0_t), .answer1(a1_t), .answer2(a2_t), .answer3(a3_t),
    .timeout_evt(tevt_t)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [7:0] dest;
    logic [3:0] last;
    logic [3:0] grant;
    logic [2:0] a0, a1, a2, a3;
    logic [3:0] to;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] rq, input logic [7:0] ds,
                     input logic [3:0] ls, input logic [3:0] g, input logic [2:0] x0,
                     input logic [2:0] x1, input logic [2:0] x2, input logic [2:0] x3,
                     input logic [3:0] to);
    vec_t v;
    v.rst = rst; v.req = rq; v.dest = ds; v.last = ls; v.grant = g;
    v.a0 = x0; v.a1 = x1; v.a2 = x2; v.a3 = x3; v.to = to;
    vecs.push_back(v);
  endtask

  // Packed layout: {grant, answer0, answer1, answer2, answer3, timeout_evt}
  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got grant=%b ans0..3=%b,%b,%b,%b tevt=%b, expected grant=%b ans0..3=%b,%b,%b,%b tevt=%b",
               name, act[19:16], act[15:13], act[12:10], act[9:7], act[6:4], act[3:0],
               exp[19:16], exp[15:13], exp[12:10], exp[9:7], exp[6:4], exp[3:0]);
    end
  endtask

  function automatic logic [19:0] act_main();
    return {grant, a0, a1, a2, a3, tevt};
  endfunction

  function automatic logic [19:0] act_to();
    return {grant_t, a0_t, a1_t, a2_t, a3_t, tevt_t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_o;
    reset = 1'b1; req = '0; req_dest = '0; req_last = '0;

    // Reset with all requests asserted
    add(1, 4'hF, 8'hE4, 4'h0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0);
    add(1, 4'hF, 8'hE4, 4'h0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0);
    // Input 0 to output 2, held, dest change ignored, then last
    add(0, 4'h1, 8'h02, 4'h0, 4'h1, 3'd0, 3'd0, 3'b100, 3'd0, 4'h0);
    add(0, 4'h1, 8'h02, 4'h0, 4'h1, 3'd0, 3'd0, 3'b100, 3'd0, 4'h0);
    add(0, 4'h1, 8'h02, 4'h0, 4'h1, 3'd0, 3'd0, 3'b100, 3'd0, 4'h0);
    add(0, 4'h1, 8'h03, 4'h0, 4'h1, 3'd0, 3'd0, 3'b100, 3'd0, 4'h0);
    add(0, 4'h1, 8'h02, 4'h0, 4'h1, 3'd0, 3'd0, 3'b100, 3'd0, 4'h0);
    add(0, 4'h1, 8'h02, 4'h1, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0);
    add(0, 4'h0, 8'h02, 4'h0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0);
    // req_last while not granted does not block the grant; dropping req releases
    add(0, 4'h1, 8'h02, 4'h1, 4'h1, 3'd0, 3'd0, 3'b100, 3'd0, 4'h0);
    add(0, 4'h0, 8'h02, 4'h0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0);
    // Four distinct destinations in one cycle
    add(0, 4'hF, 8'h1B, 4'h0, 4'hF, 3'b111, 3'b110, 3'b101, 3'b100, 4'h0);
    add(0, 4'hF, 8'h1B, 4'hF, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0);
    add(0, 4'h0, 8'h1B, 4'h0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0);
    // Reset mid-packet, then rr_ptr of output 1 is back at 0
    add(0, 4'h4, 8'h10, 4'h0, 4'h4, 3'd0, 3'b110, 3'd0, 3'd0, 4'h0);
    add(1, 4'h4, 8'h10, 4'h0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0);
    add(0, 4'h9, 8'h41, 4'h0, 4'h1, 3'd0, 3'b100, 3'd0, 3'd0, 4'h0);
    add(0, 4'h8, 8'h41, 4'h0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0);
    add(0, 4'h8, 8'h41, 4'h0, 4'h8, 3'd0, 3'b111, 3'd0, 3'd0, 4'h0);
    add(0, 4'h0, 8'h41, 4'h0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0);

    foreach (vecs[n]) begin
      reset = vecs[n].rst; req = vecs[n].req; req_dest = vecs[n].dest; req_last = vecs[n].last;
      tick();
      chk($sformatf("vec%0d", n), act_main(),
          {vecs[n].grant, vecs[n].a0, vecs[n].a1, vecs[n].a2, vecs[n].a3, vecs[n].to});
    end

    // Round-robin rotation on output 1 with 3-beat packets
    reset = 1'b1; req = '0; req_last = '0;
    tick();
    chk("rr_reset", act_main(), 20'h0);
    reset = 1'b0; req = 4'hF; req_dest = 8'h55;
    for (int n = 0; n < 5; n++) begin
      exp_o = 2'(n % 4);
      tick();
      chk($sformatf("rr_grant%0d", n), act_main(),
          {4'(1 << exp_o), 3'd0, {1'b1, exp_o}, 3'd0, 3'd0, 4'h0});
      for (int b = 0; b < 2; b++) begin
        tick();
        chk($sformatf("rr_hold%0d_%0d", n, b), act_main(),
            {4'(1 << exp_o), 3'd0, {1'b1, exp_o}, 3'd0, 3'd0, 4'h0});
      end
      req_last = 4'(1 << exp_o);
      tick();
      req_last = '0;
      chk($sformatf("rr_bubble%0d", n), act_main(), 20'h0);
    end

    // Hold timer (TIMEOUT_MAX=4) on output 0 with input 1
    reset = 1'b1; req = '0; req_last = '0;
    tick();
    chk("to_reset", act_to(), 20'h0);
    reset = 1'b0; req = 4'h2; req_dest = 8'h00;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("to_busy%0d", c), act_to(), {4'h2, 3'b101, 3'd0, 3'd0, 3'd0, 4'h0});
    end
    tick();
    chk("to_release", act_to(), {4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'h1});
    tick();
    chk("to_regrant", act_to(), {4'h2, 3'b101, 3'd0, 3'd0, 3'd0, 4'h0});
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("to_busy2_%0d", c), act_to(), {4'h2, 3'b101, 3'd0, 3'd0, 3'd0, 4'h0});
    end
    // Last on the expiring cycle is a normal release without the timeout pulse
    req_last = 4'h2;
    tick();
    req_last = '0; req = '0;
    chk("to_last_same_cycle", act_to(), 20'h0);
    tick();
    chk("to_idle", act_to(), 20'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
